// File: rtl/rr_priority_encoder16.sv
// rr_priority_encoder16: sticky 16-source request collector with fair round-robin index grants over valid/ready
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   req_in    request strobes, each high bit marks its source pending
//   out_idx   index of the granted source
//   out_valid out_idx holds a grant
//   out_ready consumer takes out_idx this cycle when out_valid is high
//   pending   registered pending vector
//   overflow  sticky, a request hit a source that was already pending
module rr_priority_encoder16 #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_in,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [W-1:0] ptr, start, idx_nx;
  logic [N-1:0] clear_mask, rem, vec;
  logic accept, load;
  // first set bit of v at or after s, wrapping; scanning downward lets the nearest bit win
  function automatic logic [W-1:0] pick(input logic [N-1:0] v, input logic [W-1:0] s);
    logic [W-1:0] r, k;
    r = s;
    for (int i = N - 1; i >= 0; i--) begin
      k = s + W'(i);
      if (v[k]) r = k;
    end
    return r;
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = out_valid ? ((accept & ~|rem) ? IDLE : HOLD) : (|pending ? HOLD : IDLE);
  assign out_valid = state == HOLD;
  // the search only ever sees registered pending, never same-cycle requests
  always_comb begin
    accept = out_valid & out_ready;
    clear_mask = accept ? N'(1) << out_idx : '0;
    rem = pending & ~clear_mask;
    vec = out_valid ? rem : pending;
    start = out_valid ? out_idx + 1'b1 : ptr;
    idx_nx = pick(vec, start);
    load = state_nx == HOLD && (!out_valid || accept);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      overflow <= 1'b0;
      ptr <= '0;
      out_idx <= '0;
    end else begin
      pending <= rem | req_in;
      overflow <= overflow | |(req_in & rem);
      if (accept) ptr <= out_idx + 1'b1;
      if (load) out_idx <= idx_nx;
    end
endmodule

// File: tb/tb_rr_priority_encoder16.sv
// tb_rr_priority_encoder16: scoreboard bench with a bit-level reference model and random plus directed stimulus
module tb_rr_priority_encoder16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] req_in = '0;
  logic out_ready = 1'b0;
  logic [3:0] out_idx;
  logic out_valid;
  logic [15:0] pending;
  logic overflow;
  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  logic [15:0] m_pend = '0;
  bit m_valid = 0;
  bit m_ovf = 0;
  int m_idx = 0;
  int m_ptr = 0;

  rr_priority_encoder16 dut (
    .clk(clk), .reset(reset), .req_in(req_in), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [15:0] v, input int s);
    for (int k = 0; k < 16; k++)
      if (v[(s + k) % 16]) return (s + k) % 16;
    return -1;
  endfunction

  // reference model: pending as a set, pointer as an integer, grants pushed to the scoreboard
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_pend = '0;
      m_valid = 0;
      m_ovf = 0;
      m_idx = 0;
      m_ptr = 0;
      exp_q.delete();
    end else begin
      logic [15:0] rem;
      bit acc;
      acc = m_valid && out_ready;
      for (int i = 0; i < 16; i++) begin
        rem[i] = m_pend[i] && !(acc && m_idx == i);
        if (req_in[i] && rem[i]) m_ovf = 1;
      end
      if (!m_valid) begin
        if (rem != 0) begin
          m_idx = search(rem, m_ptr);
          m_valid = 1;
          exp_q.push_back(m_idx);
        end
      end else if (acc) begin
        m_ptr = (m_idx + 1) % 16;
        if (rem != 0) begin
          m_idx = search(rem, m_ptr);
          exp_q.push_back(m_idx);
        end else m_valid = 0;
      end
      m_pend = rem | req_in;
    end
  end

  // monitor: pops an expected grant whenever the DUT offers one that will be accepted
  always @(negedge clk) begin
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("grant_unexpected", 32'(out_idx), 32'hFFFF_FFFF);
      else chk("grant_idx", 32'(out_idx), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input logic [15:0] r, input logic rdy);
    @(negedge clk);
    req_in = r;
    out_ready = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    req_in = 16'($urandom);
    out_ready = 1'($urandom);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req_in = '0;
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(16'($urandom), 1'($urandom));
    do_reset();
    idle(10);
    cyc(16'h0010, 1'b1);
    idle(3);
    cyc(16'h0011, 1'b1);
    idle(4);
    do_reset();
    cyc(16'h0008, 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    cyc(16'h0002, 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    idle(4);
    cyc(16'h0004, 1'b1);
    cyc('0, 1'b1);
    cyc(16'h0004, 1'b1);
    idle(5);
    chk("no_ovf_on_accept", 32'(overflow), 32'd0);
    do_reset();
    cyc(16'h0080, 1'b0);
    cyc(16'h0080, 1'b0);
    cyc('0, 1'b0);
    cyc(16'h0080, 1'b0);
    idle(4);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    cyc(16'hFFFF, 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    do_reset();
    cyc(16'h8000, 1'b1);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      cyc(16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0));
      if (i % 1000 == 999) do_reset();
    end
    idle(40);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_priority_encoder16.md
Name: rr_priority_encoder16

Overview:
Sixteen-to-four registered round-robin encoder. It is the inverse of the 4-to-16 select decoder.
- Collects request strobes from 16 sources into a sticky pending vector.
- Serially emits the 4-bit index of each pending source over a valid/ready handshake, granting fairly by round-robin.
- Sits between per-register or per-unit event sources and pipeline logic that consumes one encoded index per cycle, e.g. writeback or hazard-release sequencing.

Parameters:
N, 16, number of request lines (fixed at 16 for this revision)
W, 4, index width, equal to log2(N)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_in  input  16  request strobes; any bit high in a cycle marks that source pending
out_idx  output  4  encoded index of the granted source
out_valid  output  1  out_idx holds a valid grant
out_ready  input  1  consumer accepts out_idx this cycle when out_valid=1
pending  output  16  current pending vector (registered)
overflow  output  1  sticky flag: a request arrived for a source already pending

Behaviour:
- Reset (async, immediate, any state):
  - pending=0, out_valid=0, out_idx=0, overflow=0.
  - Round-robin pointer ptr=0; state=IDLE.
- Accept: accept = out_valid & out_ready. clear_mask = accept ? onehot(out_idx) : 0.
- Pending update: pending_next = (pending & ~clear_mask) | req_in. Set wins over clear on the same bit.
- Overflow: set when req_in[i] & pending[i] & ~clear_mask[i] for any i. Stays set until reset.
  - A request on the bit being accepted that same cycle is not an overflow. That bit stays pending and is granted again later.
- Search function pick(vec, start): first set bit at index start, start+1, ..., 15, then wrapping to 0, ..., start-1.
- FSM states: IDLE (out_valid=0) and HOLD (out_valid=1).
- IDLE:
  - If registered pending != 0: next cycle out_idx=pick(pending, ptr), out_valid=1, go to HOLD.
  - req_in of the current cycle is not searched.
  - Latency: req_in at cycle t, pending at t+1, out_valid at t+2.
- HOLD with out_ready=0: out_idx and out_valid held stable; new requests only accumulate in pending.
- HOLD with out_ready=1:
  - ptr <= (out_idx+1) mod 16; wraps 15 to 0.
  - Let rem = pending & ~clear_mask, excluding same-cycle req_in.
  - If rem != 0: out_idx <= pick(rem, (out_idx+1) mod 16) and stay in HOLD. This gives back-to-back grants, one per cycle.
  - Else: out_valid <= 0, go to IDLE. out_idx retains its last value.
- Fairness: after source k is granted, all other pending sources are granted before k is granted again.
- Registered outputs: out_idx, out_valid, pending and overflow are all registered. No combinational path from req_in or out_ready to any output.

Test Plan:
1. Reset: assert reset mid-cycle with arbitrary inputs -> all outputs 0 immediately; after release with req_in=0 for 10 cycles -> out_valid stays 0.
2. Single request, out_ready=1:
   - req_in=16'h0010 for one cycle at t -> pending=16'h0010 at t+1; out_valid=1, out_idx=4 at t+2.
   - Then out_valid=0 and pending=0 at t+3; ptr=5.
3. Wrap-around (continues from scenario 2, ptr=5): req_in=16'h0011 for one cycle, out_ready=1 -> grants idx 0 then idx 4 on consecutive cycles, then out_valid=0.
4. Backpressure (ptr=0):
   - req_in=16'h0008, then out_ready=0 for 5 cycles -> out_idx=3 held stable.
   - req_in=16'h0002 during hold -> pending=16'h000A.
   - Raise out_ready -> idx 3, then idx 1 next cycle (search from ptr=4 wraps to 1), then idle.
5. Overflow and set-over-clear:
   - req_in bit 7 on two separate cycles while idx 7 pending and not accepted -> overflow=1, single grant of 7.
   - Separately, req_in bit 2 in the same cycle idx 2 is accepted -> overflow stays 0, idx 2 granted a second time.
6. Reset mid-HOLD: pending=16'hFFFF, out_valid=1, assert reset -> out_valid=0 and pending=0 asynchronously; after release, first grant of a new req_in=16'h8000 is idx 15.
